bidir_bus_port: RTL and testbench



---
 rtl/bus_port_pkg.sv | 16 +
 rtl/tri_state_bank.sv | 14 +
 rtl/bidir_bus_port.sv | 102 ++++++++++
 tb/tb_bidir_bus_port.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bus_port_pkg.sv
// Shared types and width helpers for the registered bidirectional bus port.
package bus_port_pkg;

  typedef enum logic [1:0] {
    LISTEN,
    TURN_ON,
    DRIVE,
    TURN_OFF
  } port_state_t;

  // A single dead cycle still needs a 1-bit counter, so never return zero.
  function automatic int turn_cnt_width(input int turn_cycles);
    return (turn_cycles > 1) ? $clog2(turn_cycles) : 1;
  endfunction

endpackage

// File: rtl/tri_state_bank.sv
// Per-bit tri-state pad drivers sharing one output enable; purely combinational.
module tri_state_bank #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             oe,
  inout  wire  [WIDTH-1:0] pad
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign pad[i] = oe ? data[i] : 1'bz;
  end

endmodule

// File: rtl/bidir_bus_port.sv
// Registered bidirectional bus port with turnaround dead cycles and a capped
// transmit burst; listens to the bus whenever it is not transmitting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LISTEN   | bus released, optional sampling into rx_data
// TURN_ON  | bus released for TURN_CYCLES before taking the bus
// DRIVE    | accepting beats, each driven for the cycle after acceptance
// TURN_OFF | bus released for TURN_CYCLES before listening again
module bidir_bus_port
  import bus_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             rx_en,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             driving
);

  localparam int TW = turn_cnt_width(TURN_CYCLES);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  port_state_t      state;
  logic [TW-1:0]    turn_cnt;
  logic [BW-1:0]    burst_cnt;
  logic [WIDTH-1:0] out_q;

  assign tx_ready = (state == DRIVE) && (burst_cnt < BURST_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LISTEN;
      driving   <= 1'b0;
      out_q     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      turn_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        LISTEN: begin
          // Sample is taken even on the edge that starts a transmit request.
          if (rx_en) begin
            rx_data  <= bus;
            rx_valid <= 1'b1;
          end
          if (tx_valid) begin
            state    <= TURN_ON;
            turn_cnt <= TURN_LOAD;
          end
        end
        TURN_ON: begin
          if (!tx_valid) begin
            state <= LISTEN;
          end else if (turn_cnt == '0) begin
            state     <= DRIVE;
            burst_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (tx_valid && tx_ready) begin
            out_q   <= tx_data;
            driving <= 1'b1;
            if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
          end else begin
            driving  <= 1'b0;
            state    <= TURN_OFF;
            turn_cnt <= TURN_LOAD;
          end
        end
        TURN_OFF: begin
          if (turn_cnt == '0) state <= LISTEN;
          else                turn_cnt <= turn_cnt - 1'b1;
        end
        default: state <= LISTEN;
      endcase
    end
  end

  tri_state_bank #(
    .WIDTH(WIDTH)
  ) u_pads (
    .data(out_q),
    .oe  (driving),
    .pad (bus)
  );

endmodule

// File: tb/tb_bidir_bus_port.sv
// Directed vector bench for bidir_bus_port (WIDTH=8, TURN_CYCLES=2, MAX_BURST=4).
module tb_bidir_bus_port;

  typedef struct {
    logic       rst;
    logic       txv;
    logic [7:0] txd;
    logic       rxe;
    logic       tbd;
    logic [7:0] tbv;
    logic       e_rdy;
    logic       e_drv;
    logic [7:0] e_bus;
    logic       e_rxv;
    logic       c_rxd;
    logic [7:0] e_rxd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       driving;
  logic       tb_drv;
  logic [7:0] tb_val;
  wire  [7:0] bus;

  int checks = 0;
  int failures = 0;
  vec_t vec[$];

  assign bus = tb_drv ? tb_val : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  bidir_bus_port #(
    .WIDTH(8),
    .TURN_CYCLES(2),
    .MAX_BURST(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_en   (rx_en),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .driving (driving)
  );

  task automatic add(input logic r, input logic txv, input logic [7:0] txd,
                     input logic rxe, input logic tbd, input logic [7:0] tbv,
                     input logic e_rdy, input logic e_drv, input logic [7:0] e_bus,
                     input logic e_rxv, input logic c_rxd, input logic [7:0] e_rxd);
    vec_t v;
    v.rst = r; v.txv = txv; v.txd = txd; v.rxe = rxe; v.tbd = tbd; v.tbv = tbv;
    v.e_rdy = e_rdy; v.e_drv = e_drv; v.e_bus = e_bus;
    v.e_rxv = e_rxv; v.c_rxd = c_rxd; v.e_rxd = e_rxd;
    vec.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_en = 1'b0;
    tb_drv = 1'b0; tb_val = 8'h00;

    //   rst txv txd    rxe tbd tbv    rdy drv bus    rxv crx rxd
    // reset with a pending request, then the delayed TURN_ON
    add(1, 1, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 1, 8'h00);
    add(1, 1, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 1, 8'h00);
    add(0, 1, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 1, 8'h00);
    add(0, 1, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 8'h00,  1, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    // receive
    add(0, 0, 8'h00, 1, 1, 8'hA5,  0, 0, 8'h00,  1, 1, 8'hA5);
    add(0, 0, 8'h00, 1, 1, 8'h5A,  0, 0, 8'h00,  1, 1, 8'h5A);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 1, 8'h5A);
    // single write
    add(0, 1, 8'h3C, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h3C, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h3C, 0, 0, 8'h00,  1, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h3C, 0, 0, 8'h00,  1, 1, 8'h3C,  0, 0, 8'h00);
    add(0, 0, 8'h3C, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 8'h77,  0, 0, 8'h00,  1, 1, 8'h77);
    // burst cap and re-arbitration
    add(0, 1, 8'h01, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00,  1, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00,  1, 1, 8'h01,  0, 0, 8'h00);
    add(0, 1, 8'h02, 0, 0, 8'h00,  1, 1, 8'h02,  0, 0, 8'h00);
    add(0, 1, 8'h03, 0, 0, 8'h00,  1, 1, 8'h03,  0, 0, 8'h00);
    add(0, 1, 8'h04, 0, 0, 8'h00,  0, 1, 8'h04,  0, 0, 8'h00);
    add(0, 1, 8'h05, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h05, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h05, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h05, 1, 1, 8'h96,  0, 0, 8'h00,  1, 1, 8'h96);
    add(0, 1, 8'h05, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h05, 0, 0, 8'h00,  1, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h05, 0, 0, 8'h00,  1, 1, 8'h05,  0, 0, 8'h00);
    add(0, 1, 8'h06, 0, 0, 8'h00,  1, 1, 8'h06,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    // abort in TURN_ON
    add(0, 1, 8'hAB, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'hAB, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 8'h3F,  0, 0, 8'h00,  1, 1, 8'h3F);
    // reset mid-drive, then a full window
    add(0, 1, 8'h01, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00,  1, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00,  1, 1, 8'h01,  0, 0, 8'h00);
    add(0, 1, 8'h02, 0, 0, 8'h00,  1, 1, 8'h02,  0, 0, 8'h00);
    add(1, 1, 8'h03, 0, 0, 8'h00,  0, 0, 8'h00,  0, 1, 8'h00);
    add(0, 1, 8'h03, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h03, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h03, 0, 0, 8'h00,  1, 0, 8'h00,  0, 0, 8'h00);
    add(0, 1, 8'h03, 0, 0, 8'h00,  1, 1, 8'h03,  0, 0, 8'h00);
    add(0, 1, 8'h04, 0, 0, 8'h00,  1, 1, 8'h04,  0, 0, 8'h00);
    add(0, 1, 8'h05, 0, 0, 8'h00,  1, 1, 8'h05,  0, 0, 8'h00);
    add(0, 1, 8'h06, 0, 0, 8'h00,  0, 1, 8'h06,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 8'h00,  0, 0, 8'h00);

    #2;
    for (int i = 0; i < vec.size(); i++) begin
      rst = vec[i].rst; tx_valid = vec[i].txv; tx_data = vec[i].txd;
      rx_en = vec[i].rxe; tb_drv = vec[i].tbd; tb_val = vec[i].tbv;
      step();
      chk("tx_ready", i, {7'd0, tx_ready}, {7'd0, vec[i].e_rdy});
      chk("driving",  i, {7'd0, driving},  {7'd0, vec[i].e_drv});
      chk("rx_valid", i, {7'd0, rx_valid}, {7'd0, vec[i].e_rxv});
      if (vec[i].e_drv) chk("bus", i, bus, vec[i].e_bus);
      if (vec[i].c_rxd) chk("rx_data", i, rx_data, vec[i].e_rxd);
    end

    // Hand sequence: ready latency from a fresh LISTEN, bounded wait.
    tx_valid = 1'b1; tx_data = 8'hAA; rx_en = 1'b0; tb_drv = 1'b0;
    n = 0;
    while (!tx_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_latency", 100, 8'(n), 8'd3);
    step();
    chk("hand_bus", 101, bus, 8'hAA);
    chk("hand_driving", 101, {7'd0, driving}, 8'd1);
    tx_valid = 1'b0;
    step();
    chk("hand_release", 102, {7'd0, driving}, 8'd0);
    chk("hand_ready_off", 102, {7'd0, tx_ready}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
